// File: rtl/serial_parity_checker.sv
// serial_parity_checker: receive-side partner of the even parity generator.
// Deserialises DATA_W data bits (LSB first) plus one parity bit, recomputes the
// parity, and presents the word with a one-cycle data_valid pulse and an error flag.
// Optional feature: define PARITY_ERR_COUNT_EN to build the saturating 8-bit
// parity error counter; otherwise err_cnt is tied to zero.
module serial_parity_checker #(
    parameter int DATA_W     = 3,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              din,
    input  logic              din_valid,
    input  logic              frame_start,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              busy,
    output logic [7:0]        err_cnt
);

    localparam int   CNT_W   = $clog2(DATA_W + 1);
    localparam logic ODD_SEL = (PARITY_ODD != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  shift_reg;

    // Mismatch between recomputed parity of the word and the received parity bit.
    function automatic logic calc_err(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p ^ ODD_SEL;
    endfunction

    // A parity bit is consumed only when it is not overridden by a new frame start.
    logic parity_take;
    assign parity_take = din_valid && !frame_start && (state == PARITY);

    // Frame FSM: deserialise data bits, check parity, register the outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shift_reg  <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            if (din_valid) begin
                if (frame_start) begin
                    // New frame, also aborts any frame in progress without a pulse.
                    shift_reg <= {{(DATA_W-1){1'b0}}, din};
                    cnt       <= CNT_W'(1);
                    state     <= DATA;
                    busy      <= 1'b1;
                end else begin
                    case (state)
                        IDLE: begin
                            // Stray bits outside a frame are ignored.
                        end
                        DATA: begin
                            for (int i = 0; i < DATA_W; i++) begin
                                if (cnt == CNT_W'(i)) shift_reg[i] <= din;
                            end
                            cnt <= cnt + CNT_W'(1);
                            if (cnt == CNT_W'(DATA_W - 1)) state <= PARITY;
                        end
                        PARITY: begin
                            data_out   <= shift_reg;
                            parity_err <= calc_err(shift_reg, din);
                            data_valid <= 1'b1;
                            cnt        <= '0;
                            state      <= IDLE;
                            busy       <= 1'b0;
                        end
                        default: begin
                            cnt   <= '0;
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [7:0] err_cnt_q;

    // Saturating increment so the count sticks at 8'hFF instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // Count completed frames that failed the parity check.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt_q <= 8'h00;
        end else if (parity_take && calc_err(shift_reg, din)) begin
            err_cnt_q <= sat_inc(err_cnt_q);
        end
    end

    assign err_cnt = err_cnt_q;
`else
    assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// Testbench for serial_parity_checker: an even-parity and an odd-parity instance
// share one bit stream; a frame-level model predicts every output each cycle.
module tb_serial_parity_checker;

    localparam int DW = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          din = 1'b0;
    logic          din_valid = 1'b0;
    logic          frame_start = 1'b0;

    logic [DW-1:0] data_out0, data_out1;
    logic          data_valid0, data_valid1;
    logic          parity_err0, parity_err1;
    logic          busy0, busy1;
    logic [7:0]    err_cnt0, err_cnt1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(0)) dut_even (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .data_out(data_out0), .data_valid(data_valid0),
        .parity_err(parity_err0), .busy(busy0), .err_cnt(err_cnt0)
    );

    serial_parity_checker #(.DATA_W(DW), .PARITY_ODD(1)) dut_odd (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .frame_start(frame_start), .data_out(data_out1), .data_valid(data_valid1),
        .parity_err(parity_err1), .busy(busy1), .err_cnt(err_cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level model ----------------
    bit         q[$];
    bit         m_active = 0;
    bit         m_valid = 0;
    int         m_data = 0;
    bit         m_err_e = 0, m_err_o = 0;
    int         m_cnt_e = 0, m_cnt_o = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_active = 0; m_valid = 0; m_data = 0;
            m_err_e = 0; m_err_o = 0; m_cnt_e = 0; m_cnt_o = 0;
        end else begin
            m_valid = 0;
            if (din_valid) begin
                if (frame_start) begin
                    q.delete();
                    q.push_back(din);
                    m_active = 1;
                end else if (m_active) begin
                    if (q.size() < DW) begin
                        q.push_back(din);
                    end else begin
                        int ones;
                        ones = 0;
                        m_data = 0;
                        foreach (q[i]) begin
                            m_data += int'(q[i]) * (1 << i);
                            ones += int'(q[i]);
                        end
                        ones += int'(din);
                        m_err_e = (ones % 2) != 0;   // even parity: total ones must be even
                        m_err_o = (ones % 2) == 0;   // odd parity: total ones must be odd
                        if (m_err_e && m_cnt_e < 255) m_cnt_e++;
                        if (m_err_o && m_cnt_o < 255) m_cnt_o++;
                        m_valid = 1;
                        m_active = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        chk("data_out_e",   32'(data_out0),   32'(m_data));
        chk("data_valid_e", 32'(data_valid0), 32'(m_valid));
        chk("parity_err_e", 32'(parity_err0), 32'(m_err_e));
        chk("busy_e",       32'(busy0),       32'(m_active));
        chk("data_out_o",   32'(data_out1),   32'(m_data));
        chk("data_valid_o", 32'(data_valid1), 32'(m_valid));
        chk("parity_err_o", 32'(parity_err1), 32'(m_err_o));
        chk("busy_o",       32'(busy1),       32'(m_active));
`ifdef PARITY_ERR_COUNT_EN
        chk("err_cnt_e", 32'(err_cnt0), 32'(m_cnt_e));
        chk("err_cnt_o", 32'(err_cnt1), 32'(m_cnt_o));
`else
        chk("err_cnt_e", 32'(err_cnt0), 32'h0);
        chk("err_cnt_o", 32'(err_cnt1), 32'h0);
`endif
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic fs, input logic d);
        @(negedge clk);
        din_valid   = v;
        frame_start = fs;
        din         = d;
    endtask

    task automatic frame_bits(input logic [2:0] d, input logic p);
        drive(1, 1, d[0]);
        drive(1, 0, d[1]);
        drive(1, 0, d[2]);
        drive(1, 0, p);
    endtask

    initial begin
        logic [2:0] v;
        rst_n = 1'b0;
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("rst_data_out", 32'(data_out0), 32'h0);
        chk("rst_busy", 32'(busy0), 32'h0);
        chk("rst_err_cnt", 32'(err_cnt0), 32'h0);
        rst_n = 1'b1;
        drive(0, 0, 0);

        // 1: 1,0,1 p=0 -> 3'b101, no error, single-cycle pulse
        frame_bits(3'b101, 1'b0);
        drive(0, 0, 0);
        chk("t1_data_out", 32'(data_out0), 32'h5);
        chk("t1_valid", 32'(data_valid0), 32'h1);
        chk("t1_err", 32'(parity_err0), 32'h0);
        chk("t1_busy_after", 32'(busy0), 32'h0);
        drive(0, 0, 0);
        chk("t1_valid_drop", 32'(data_valid0), 32'h0);
        chk("t1_data_hold", 32'(data_out0), 32'h5);

        // 2: same data, p=1 -> error, counter 0->1 when built
        frame_bits(3'b101, 1'b1);
        drive(0, 0, 0);
        chk("t2_err", 32'(parity_err0), 32'h1);
`ifdef PARITY_ERR_COUNT_EN
        chk("t2_err_cnt", 32'(err_cnt0), 32'h1);
`else
        chk("t2_err_cnt", 32'(err_cnt0), 32'h0);
`endif

        // 3: bits 1,1,0 with 2-cycle gaps, p=0 -> 3'b011; busy through gaps
        drive(1, 1, 1);
        drive(0, 1, 0);                 // frame_start without din_valid: no effect
        chk("t3_busy_gap", 32'(busy0), 32'h1);
        drive(0, 0, 0);
        drive(1, 0, 1);
        drive(0, 0, 1);
        chk("t3_busy_gap2", 32'(busy0), 32'h1);
        drive(0, 0, 1);
        drive(1, 0, 0);
        drive(0, 0, 0);
        drive(0, 0, 0);
        chk("t3_busy_gap3", 32'(busy0), 32'h1);
        drive(1, 0, 0);
        drive(0, 0, 0);
        chk("t3_data_out", 32'(data_out0), 32'h3);
        chk("t3_err", 32'(parity_err0), 32'h0);
        chk("t3_valid", 32'(data_valid0), 32'h1);

        // 4: abort after 2 bits, new frame 0,0,0 p=0
        drive(1, 1, 1);
        drive(1, 0, 1);
        drive(1, 1, 0);
        drive(1, 0, 0);
        chk("t4_no_pulse", 32'(data_valid0), 32'h0);
        drive(1, 0, 0);
        drive(1, 0, 0);
        drive(0, 0, 0);
        chk("t4_data_out", 32'(data_out0), 32'h0);
        chk("t4_valid", 32'(data_valid0), 32'h1);
        chk("t4_err", 32'(parity_err0), 32'h0);

        // back-to-back: 0,1,1 p=0 then frame_start right after parity
        frame_bits(3'b110, 1'b0);
        drive(1, 1, 1);
        chk("b2b_valid", 32'(data_valid0), 32'h1);
        chk("b2b_data_out", 32'(data_out0), 32'h6);
        drive(1, 0, 0);
        chk("b2b_busy", 32'(busy0), 32'h1);
        drive(1, 0, 0);
        drive(1, 0, 0);                 // 1,0,0 with p=0 -> parity error
        drive(0, 0, 0);
        chk("b2b2_data_out", 32'(data_out0), 32'h1);
        chk("b2b2_err", 32'(parity_err0), 32'h1);

        // 5: reset mid-frame after 2 bits
        drive(1, 1, 1);
        drive(1, 0, 1);
        rst_n = 1'b0;
        drive(0, 0, 0);
        rst_n = 1'b1;
        chk("t5_busy", 32'(busy0), 32'h0);
        chk("t5_data_out", 32'(data_out0), 32'h0);
        chk("t5_err", 32'(parity_err0), 32'h0);
        chk("t5_valid", 32'(data_valid0), 32'h0);
        chk("t5_err_cnt", 32'(err_cnt0), 32'h0);
        frame_bits(3'b111, 1'b1);
        drive(0, 0, 0);
        chk("t5_data_out2", 32'(data_out0), 32'h7);
        chk("t5_err2", 32'(parity_err0), 32'h0);

        // 6: odd-parity instance with 1,0,1 p=1 -> no error there
        frame_bits(3'b101, 1'b1);
        drive(0, 0, 0);
        chk("t6_odd_err", 32'(parity_err1), 32'h0);
        chk("t6_even_err", 32'(parity_err0), 32'h1);

        // 6: 260 bad-parity frames saturate the counter
        for (int i = 0; i < 260; i++) begin
            frame_bits(3'b001, 1'b0);
        end
        drive(0, 0, 0);
        drive(0, 0, 0);
`ifdef PARITY_ERR_COUNT_EN
        chk("t6_err_cnt_sat", 32'(err_cnt0), 32'hFF);
`else
        chk("t6_err_cnt_sat", 32'(err_cnt0), 32'h0);
`endif

        // 7: every data value with generator parity -> never an error
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            frame_bits(v, ^v);
            drive(0, 0, 0);
            chk("t7_data_out", 32'(data_out0), 32'(i));
            chk("t7_err", 32'(parity_err0), 32'h0);
        end
`ifdef PARITY_ERR_COUNT_EN
        chk("t7_err_cnt_hold", 32'(err_cnt0), 32'hFF);
`endif

        drive(0, 0, 0);
        drive(0, 0, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
